chess_move_entry: RTL and testbench

Parametrised keyboard move-entry engine for the chess design. It consumes the ASCII strobe stream from the PS/2 keyboard decoder and parses coordinate moves such as "e2e4", with an optional promotion letter. Committed moves are queued in a small FIFO toward the chess state machine through a valid/ready handshake. Partial-entry echo outputs let the display highlight squares as they are typed.

---
 rtl/chess_move_entry_if.sv | 24 ++
 rtl/chess_move_entry.sv | 225 ++++++++++++++++++++++
 tb/tb_chess_move_entry.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chess_move_entry_if.sv
// Committed-move queue handshake between the keyboard move-entry engine and the chess state machine.
interface chess_move_entry_if #(
    parameter int COORD_W    = 3,
    parameter int FIFO_DEPTH = 4
);
    logic                          move_valid;
    logic                          move_ready;
    logic [4*COORD_W+2:0]          move_data;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output move_valid,
        output move_data,
        output fifo_count,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  move_data,
        input  fifo_count,
        output move_ready
    );
endinterface

// File: rtl/chess_move_entry.sv
// Keyboard coordinate-move parser ("e2e4" + optional promotion letter + Enter) feeding a small
// committed-move FIFO, with partial-entry echo for square highlighting.
module chess_move_entry #(
    parameter int BOARD_N    = 8,
    parameter int COORD_W    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int PROMO_EN   = 1
) (
    input  logic                   CLOCK_27,
    input  logic                   RESET_N,
    input  logic [7:0]             ascii,
    input  logic                   new_ascii,
    chess_move_entry_if.master     move_if,
    output logic                   side,
    output logic [2:0]             entry_state,
    output logic [2*COORD_W-1:0]   echo_from,
    output logic [2*COORD_W-1:0]   echo_to,
    output logic                   err
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int MOVE_W = 4*COORD_W + 3;

    localparam logic [7:0] KEY_ENTER = 8'h0D;
    localparam logic [7:0] KEY_BS    = 8'h08;
    localparam logic [7:0] KEY_ESC   = 8'h1B;
    localparam logic [7:0] FILE_LAST = 8'(8'h61 + BOARD_N - 1);
    localparam logic [7:0] RANK_LAST = 8'(8'h30 + BOARD_N);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        FROM_FILE = 3'd0,
        FROM_RANK = 3'd1,
        TO_FILE   = 3'd2,
        TO_RANK   = 3'd3,
        PROMO     = 3'd4,
        CONFIRM   = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic [COORD_W-1:0]   from_file_reg, from_file_next;
    logic [COORD_W-1:0]   from_rank_reg, from_rank_next;
    logic [COORD_W-1:0]   to_file_reg, to_file_next;
    logic [COORD_W-1:0]   to_rank_reg, to_rank_next;
    logic [1:0]           promo_reg, promo_next;
    logic                 side_reg, side_next;
    logic                 err_reg, err_next;

    logic [PTR_W-1:0]     rd_ptr_reg, wr_ptr_reg;
    logic [PTR_W:0]       count_reg;
    logic [MOVE_W-1:0]    slot_data [FIFO_DEPTH];
    logic [MOVE_W-1:0]    push_data;
    logic                 push, pop, commit_req, commit_ok;

    // Key decode; letters are folded to lowercase so files and promotion pieces accept either case.
    logic [7:0]           key_lc;
    logic                 is_file, is_rank, is_promo;
    logic [COORD_W-1:0]   file_val, rank_val;
    logic [1:0]           promo_val;

    always_comb begin
        key_lc    = (ascii >= 8'h41 && ascii <= 8'h5A) ? (ascii | 8'h20) : ascii;
        is_file   = (key_lc >= 8'h61) && (key_lc <= FILE_LAST);
        is_rank   = (ascii >= 8'h31) && (ascii <= RANK_LAST);
        file_val  = COORD_W'(key_lc - 8'h61);
        rank_val  = COORD_W'(ascii - 8'h31);
        is_promo  = 1'b1;
        promo_val = 2'd0;
        case (key_lc)
            8'h71:   promo_val = 2'd0;
            8'h72:   promo_val = 2'd1;
            8'h62:   promo_val = 2'd2;
            8'h6E:   promo_val = 2'd3;
            default: is_promo  = 1'b0;
        endcase
    end

    assign move_if.move_valid = (count_reg != '0);
    assign pop       = move_if.move_valid & move_if.move_ready;
    assign commit_ok = (count_reg != FULL_CNT) || pop;
    assign push_data = {side_reg, promo_reg, from_file_reg, from_rank_reg, to_file_reg, to_rank_reg};

    always_comb begin
        state_next     = state_reg;
        from_file_next = from_file_reg;
        from_rank_next = from_rank_reg;
        to_file_next   = to_file_reg;
        to_rank_next   = to_rank_reg;
        promo_next     = promo_reg;
        side_next      = side_reg;
        err_next       = 1'b0;
        commit_req     = 1'b0;
        push           = 1'b0;

        if (new_ascii) begin
            if (ascii == KEY_ESC) begin
                from_file_next = '0;
                from_rank_next = '0;
                to_file_next   = '0;
                to_rank_next   = '0;
                promo_next     = '0;
                state_next     = FROM_FILE;
            end else if (ascii == KEY_BS) begin
                // Step back one state and clear the field that state collects.
                case (state_reg)
                    FROM_RANK: begin from_file_next = '0; state_next = FROM_FILE; end
                    TO_FILE:   begin from_rank_next = '0; state_next = FROM_RANK; end
                    TO_RANK:   begin to_file_next   = '0; state_next = TO_FILE;   end
                    PROMO:     begin to_rank_next   = '0; state_next = TO_RANK;   end
                    CONFIRM: begin
                        if (PROMO_EN != 0) begin
                            promo_next = '0;
                            state_next = PROMO;
                        end else begin
                            to_rank_next = '0;
                            state_next   = TO_RANK;
                        end
                    end
                    default: state_next = state_reg;
                endcase
            end else begin
                case (state_reg)
                    FROM_FILE: if (is_file) begin from_file_next = file_val; state_next = FROM_RANK; end
                               else err_next = 1'b1;
                    FROM_RANK: if (is_rank) begin from_rank_next = rank_val; state_next = TO_FILE; end
                               else err_next = 1'b1;
                    TO_FILE:   if (is_file) begin to_file_next = file_val; state_next = TO_RANK; end
                               else err_next = 1'b1;
                    TO_RANK: begin
                        if (!is_rank) begin
                            err_next = 1'b1;
                        end else if (to_file_reg == from_file_reg && rank_val == from_rank_reg) begin
                            err_next     = 1'b1;
                            to_file_next = '0;
                            state_next   = TO_FILE;
                        end else begin
                            to_rank_next = rank_val;
                            state_next   = (PROMO_EN != 0) ? PROMO : CONFIRM;
                        end
                    end
                    PROMO: begin
                        if (is_promo) begin
                            promo_next = promo_val;
                            state_next = CONFIRM;
                        end else if (ascii == KEY_ENTER) begin
                            commit_req = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                    CONFIRM:   if (ascii == KEY_ENTER) commit_req = 1'b1;
                               else err_next = 1'b1;
                    default:   state_next = FROM_FILE;
                endcase
            end
        end

        // A full queue refuses the commit unless the head leaves this same cycle.
        if (commit_req) begin
            if (commit_ok) begin
                push           = 1'b1;
                from_file_next = '0;
                from_rank_next = '0;
                to_file_next   = '0;
                to_rank_next   = '0;
                promo_next     = '0;
                side_next      = ~side_reg;
                state_next     = FROM_FILE;
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_27) begin
        if (!RESET_N) begin
            state_reg     <= FROM_FILE;
            from_file_reg <= '0;
            from_rank_reg <= '0;
            to_file_reg   <= '0;
            to_rank_reg   <= '0;
            promo_reg     <= '0;
            side_reg      <= 1'b0;
            err_reg       <= 1'b0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            from_file_reg <= from_file_next;
            from_rank_reg <= from_rank_next;
            to_file_reg   <= to_file_next;
            to_rank_reg   <= to_rank_next;
            promo_reg     <= promo_next;
            side_reg      <= side_next;
            err_reg       <= err_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [MOVE_W-1:0] data_reg;
            always_ff @(posedge CLOCK_27) begin
                if (push && wr_ptr_reg == PTR_W'(gi)) data_reg <= push_data;
            end
            assign slot_data[gi] = data_reg;
        end
    endgenerate

    // Empty queue presents zero so the bus is quiet out of reset.
    assign move_if.move_data  = move_if.move_valid ? slot_data[rd_ptr_reg] : '0;
    assign move_if.fifo_count = count_reg;
    assign side        = side_reg;
    assign entry_state = state_reg;
    assign echo_from   = {from_file_reg, from_rank_reg};
    assign echo_to     = {to_file_reg, to_rank_reg};
    assign err         = err_reg;
endmodule

// File: tb/tb_chess_move_entry.sv
// Directed bench: 8x8 build checked every cycle against a typed-string model plus literal spot
// checks; a 5x5 build without promotion gets literal checks only.
module tb_chess_move_entry;
    localparam int DEPTH = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ascii_a = 8'h00;
    logic       key_a   = 1'b0;
    logic [7:0] ascii_b = 8'h00;
    logic       key_b   = 1'b0;
    logic       side_a, err_a, side_b, err_b;
    logic [2:0] st_a, st_b;
    logic [5:0] ef_a, et_a, ef_b, et_b;

    int tests_run    = 0;
    int tests_failed = 0;

    chess_move_entry_if #(.COORD_W(3), .FIFO_DEPTH(DEPTH)) if_a ();
    chess_move_entry_if #(.COORD_W(3), .FIFO_DEPTH(DEPTH)) if_b ();

    always #5 clk = ~clk;

    chess_move_entry #(.BOARD_N(8), .COORD_W(3), .FIFO_DEPTH(DEPTH), .PROMO_EN(1)) dut_a (
        .CLOCK_27(clk), .RESET_N(rst_n), .ascii(ascii_a), .new_ascii(key_a), .move_if(if_a),
        .side(side_a), .entry_state(st_a), .echo_from(ef_a), .echo_to(et_a), .err(err_a)
    );

    chess_move_entry #(.BOARD_N(5), .COORD_W(3), .FIFO_DEPTH(DEPTH), .PROMO_EN(0)) dut_b (
        .CLOCK_27(clk), .RESET_N(rst_n), .ascii(ascii_b), .new_ascii(key_b), .move_if(if_b),
        .side(side_b), .entry_state(st_b), .echo_from(ef_b), .echo_to(et_b), .err(err_b)
    );

    task automatic check(input string name, input logic [31:0] got, input int exp);
        tests_run++;
        if (got !== 32'(exp)) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the entry is a position in the typed string (0..5) plus the five collected fields.
    int         pos;
    int         fld [5];
    bit         m_side, m_err, started;
    logic [14:0] q [$];

    function automatic int promo_idx(input int lc);
        case (lc)
            113:     return 0;
            114:     return 1;
            98:      return 2;
            110:     return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        bit          pop, commit, want_file, ok;
        int          c, lc, v;
        logic [14:0] item;
        started = 1'b1;
        if (!rst_n) begin
            pos = 0;
            for (int i = 0; i < 5; i++) fld[i] = 0;
            m_side = 1'b0;
            m_err  = 1'b0;
            q.delete();
        end else begin
            m_err  = 1'b0;
            commit = 1'b0;
            item   = '0;
            pop    = (q.size() != 0) && if_a.move_ready;
            if (key_a) begin
                c  = int'(ascii_a);
                lc = (c >= 65 && c <= 90) ? c + 32 : c;
                if (c == 27) begin
                    pos = 0;
                    for (int i = 0; i < 5; i++) fld[i] = 0;
                end else if (c == 8) begin
                    if (pos > 0) begin
                        pos--;
                        fld[pos] = 0;
                    end
                end else if (pos < 4) begin
                    want_file = (pos % 2 == 0);
                    ok = want_file ? (lc >= 97 && lc < 97 + 8) : (c >= 49 && c <= 48 + 8);
                    v  = want_file ? lc - 97 : c - 49;
                    if (!ok) m_err = 1'b1;
                    else if (pos == 3 && fld[2] == fld[0] && v == fld[1]) begin
                        m_err  = 1'b1;
                        fld[2] = 0;
                        pos    = 2;
                    end else begin
                        fld[pos] = v;
                        pos++;
                    end
                end else if (pos == 4 && promo_idx(lc) >= 0) begin
                    fld[4] = promo_idx(lc);
                    pos    = 5;
                end else if (c == 13) begin
                    commit = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (commit && q.size() == DEPTH && !pop) begin
                m_err  = 1'b1;
                commit = 1'b0;
            end else if (commit) begin
                item = {m_side, 2'(fld[4]), 3'(fld[0]), 3'(fld[1]), 3'(fld[2]), 3'(fld[3])};
                pos  = 0;
                for (int i = 0; i < 5; i++) fld[i] = 0;
                m_side = ~m_side;
            end
            if (pop) void'(q.pop_front());
            if (commit) q.push_back(item);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("valid", 32'(if_a.move_valid), int'(q.size() != 0));
            check("count", 32'(if_a.fifo_count), q.size());
            if (q.size() != 0) check("head", 32'(if_a.move_data), int'(q[0]));
            check("side", 32'(side_a), int'(m_side));
            check("state", 32'(st_a), pos);
            check("echo_from", 32'(ef_a), fld[0] * 8 + fld[1]);
            check("echo_to", 32'(et_a), fld[2] * 8 + fld[3]);
            check("err", 32'(err_a), int'(m_err));
        end
    end

    task automatic press_a(input logic [7:0] c);
        ascii_a = c;
        key_a   = 1'b1;
        @(posedge clk); #1;
        key_a   = 1'b0;
    endtask

    task automatic type_a(input string s);
        for (int i = 0; i < s.len(); i++) press_a(s[i]);
    endtask

    task automatic press_b(input logic [7:0] c);
        ascii_b = c;
        key_b   = 1'b1;
        @(posedge clk); #1;
        key_b   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        if_a.move_ready = 1'b0;
        if_b.move_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_valid", 32'(if_a.move_valid), 0);
        check("rst_count", 32'(if_a.fifo_count), 0);
        check("rst_state", 32'(st_a), 0);
        check("rst_b_state", 32'(st_b), 0);

        type_a("e2e4");
        check("e2e4_state", 32'(st_a), 4);
        press_a(8'h0D);
        check("e2e4_valid", 32'(if_a.move_valid), 1);
        check("e2e4_data", 32'(if_a.move_data), 'h0863);
        check("e2e4_side", 32'(side_a), 1);
        check("e2e4_state0", 32'(st_a), 0);
        if_a.move_ready = 1'b1;
        idle(1);
        if_a.move_ready = 1'b0;
        check("pop1_count", 32'(if_a.fifo_count), 0);

        type_a("a7a8N");
        press_a(8'h0D);
        check("promo_data", 32'(if_a.move_data), 'h7187);
        idle(3);
        check("promo_hold", 32'(if_a.move_data), 'h7187);
        check("promo_count", 32'(if_a.fifo_count), 1);
        if_a.move_ready = 1'b1;
        idle(1);
        if_a.move_ready = 1'b0;
        check("pop2_count", 32'(if_a.fifo_count), 0);

        type_a("e2x");
        check("bad_err", 32'(err_a), 1);
        check("bad_state", 32'(st_a), 2);
        idle(1);
        check("bad_err_clr", 32'(err_a), 0);
        press_a(8'h08);
        check("bs_state", 32'(st_a), 1);
        check("bs_echo", 32'(ef_a), 'h20);
        press_a(8'h1B);
        check("esc_state", 32'(st_a), 0);
        check("esc_echo", 32'(ef_a), 0);

        type_a("d4d4");
        check("null_err", 32'(err_a), 1);
        check("null_state", 32'(st_a), 2);
        check("null_echo_to", 32'(et_a), 0);
        check("null_echo_from", 32'(ef_a), 'h1B);
        press_a(8'h1B);

        type_a("b1c3"); press_a(8'h0D);
        type_a("E7E8q"); press_a(8'h0D);
        type_a("g1f3r"); press_a(8'h0D);
        type_a("h2h4"); press_a(8'h0D);
        check("full_count", 32'(if_a.fifo_count), 4);
        type_a("c2c4n");
        press_a(8'h0D);
        check("full_err", 32'(err_a), 1);
        check("full_state", 32'(st_a), 5);
        check("full_head", 32'(if_a.move_data), 'h0212);
        if_a.move_ready = 1'b1;
        press_a(8'h0D);
        if_a.move_ready = 1'b0;
        check("pushpop_count", 32'(if_a.fifo_count), 4);
        check("pushpop_side", 32'(side_a), 1);
        check("pushpop_head", 32'(if_a.move_data), 'h49A7);
        check("pushpop_err", 32'(err_a), 0);

        type_a("c2");
        rst_n = 1'b0;
        idle(1);
        check("mid_rst_valid", 32'(if_a.move_valid), 0);
        check("mid_rst_data", 32'(if_a.move_data), 0);
        check("mid_rst_count", 32'(if_a.fifo_count), 0);
        check("mid_rst_side", 32'(side_a), 0);
        check("mid_rst_state", 32'(st_a), 0);
        check("mid_rst_echo", 32'({ef_a, et_a}), 0);
        check("mid_rst_err", 32'(err_a), 0);
        rst_n = 1'b1;

        press_b("f");
        check("b_f_err", 32'(err_b), 1);
        check("b_f_state", 32'(st_b), 0);
        press_b("e");
        press_b("6");
        check("b_6_err", 32'(err_b), 1);
        check("b_6_state", 32'(st_b), 1);
        press_b("5");
        check("b_e5_echo", 32'(ef_b), 'h24);
        press_b("b");
        press_b("2");
        check("b_skip_promo", 32'(st_b), 5);
        check("b_echo_to", 32'(et_b), 'h09);
        press_b(8'h08);
        check("b_bs_state", 32'(st_b), 3);
        check("b_bs_echo", 32'(et_b), 'h08);
        press_b("2");
        press_b(8'h0D);
        check("b_valid", 32'(if_b.move_valid), 1);
        check("b_data", 32'(if_b.move_data), 'h0909);
        check("b_side", 32'(side_b), 1);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
